// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR family: FSM encoding and width helpers.
package fir_pkg;

  typedef logic [1:0] fir_state_t;

  localparam fir_state_t ST_IDLE = 2'd0;
  localparam fir_state_t ST_MAC  = 2'd1;
  localparam fir_state_t ST_OUT  = 2'd2;

  // Ceiling log2 with a minimum of 1 so single-bit indices stay well formed.
  function automatic int fir_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int fir_acc_w(input int dw, input int cw, input int n_taps);
    return dw + cw + fir_clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of an accumulator to DW bits.
module fir_round_sat #(
  parameter int ACC_W     = 38,
  parameter int DW        = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [DW-1:0]    y_o,
  output logic                    sat_o
);

  // One guard bit so the rounding constant can never wrap the sum.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] Y_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] Y_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] shifted;

  assign acc_ext = {acc_i[ACC_W-1], acc_i};

  if (OUT_SHIFT > 0) begin : g_round
    localparam logic signed [EW-1:0] RND = {{(EW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    logic signed [EW-1:0] rounded;
    assign rounded = acc_ext + RND;
    assign shifted = rounded >>> OUT_SHIFT;
  end else begin : g_pass
    assign shifted = acc_ext;
  end

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    y_o   = shifted[DW-1:0];
    sat_o = 1'b0;
    if (shifted > Y_MAX) begin
      y_o   = Y_MAX[DW-1:0];
      sat_o = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_o   = Y_MIN[DW-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over a runtime-writable coefficient bank.
module fir_mac_serial
  import fir_pkg::*;
#(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int N_TAPS    = 63,
  parameter int OUT_SHIFT = 15
) (
  input  logic                               clk,
  input  logic                               rst_p,
  input  logic signed [DW-1:0]               x_in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [DW-1:0]               y_out,
  output logic                               out_sat,
  output logic                               out_valid,
  input  logic                               out_ready,
  input  logic                               coef_we,
  input  logic [fir_clog2(N_TAPS)-1:0]       coef_addr,
  input  logic signed [CW-1:0]               coef_wdata,
  output logic                               coef_err,
  input  logic                               flush
);

  localparam int AW    = fir_clog2(N_TAPS);
  localparam int ACC_W = fir_acc_w(DW, CW, N_TAPS);
  localparam int PW    = DW + CW;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_TAPS - 1);
  localparam logic [AW:0]   N_TAPS_W = (AW+1)'(N_TAPS);

  fir_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] hist_q [N_TAPS];
  logic signed [CW-1:0] coef_q [N_TAPS];
  logic signed [DW-1:0] y_q, y_d, rs_y;
  logic sat_q, sat_d, rs_sat;
  logic valid_q, valid_d;
  logic coef_err_q;
  logic accept, coef_ok;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign coef_ok   = coef_we && !flush && (state_q == ST_IDLE) && ({1'b0, coef_addr} < N_TAPS_W);

  assign y_out     = y_q;
  assign out_sat   = sat_q;
  assign out_valid = valid_q;
  assign coef_err  = coef_err_q;

  assign prod    = PW'(hist_q[idx_q]) * PW'(coef_q[idx_q]);
  assign acc_sum = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Rounding sees the sum including the final tap, so the result registers on that same edge.
  fir_round_sat #(
    .ACC_W     (ACC_W),
    .DW        (DW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc_i (acc_sum),
    .y_o   (rs_y),
    .sat_o (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    y_d     = y_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      acc_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_d = acc_sum;
          idx_d = idx_q + AW'(1);
          if (idx_q == LAST_IDX) begin
            y_d     = rs_y;
            sat_d   = rs_sat;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: history and coefficients are reset explicitly because a reset must leave the filter
  // producing zeros; memories that only need valid data before use would normally skip reset.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      y_q        <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        hist_q[k] <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      coef_err_q <= coef_we && !coef_ok;
      if (flush) begin
        for (int k = 0; k < N_TAPS; k++) hist_q[k] <= '0;
      end else if (accept) begin
        hist_q[0] <= x_in;
        for (int k = 1; k < N_TAPS; k++) hist_q[k] <= hist_q[k-1];
      end
      if (coef_ok) coef_q[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed plus randomized bench: two filter instances (shift 0 and shift 15) against a sum-of-products model.
module tb_fir_mac_serial;

  localparam int N_TAPS = 4;

  logic        clk;
  logic        rst_p;
  logic [15:0] x_in;
  logic        in_valid;
  logic        out_ready;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        flush;

  logic        ready_a, valid_a, sat_a, err_a;
  logic [15:0] y_a;
  logic        ready_b, valid_b, sat_b, err_b;
  logic [15:0] y_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [15:0] m_hist [N_TAPS];
  logic signed [15:0] m_coef [N_TAPS];
  logic [15:0] exp_y_a, exp_y_b;
  logic        exp_s_a, exp_s_b;

  fir_mac_serial #(.DW(16), .CW(16), .N_TAPS(N_TAPS), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst_p(rst_p), .x_in(x_in), .in_valid(in_valid), .in_ready(ready_a),
    .y_out(y_a), .out_sat(sat_a), .out_valid(valid_a), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(err_a), .flush(flush)
  );

  fir_mac_serial #(.DW(16), .CW(16), .N_TAPS(N_TAPS), .OUT_SHIFT(15)) dut_b (
    .clk(clk), .rst_p(rst_p), .x_in(x_in), .in_valid(in_valid), .in_ready(ready_b),
    .y_out(y_b), .out_sat(sat_b), .out_valid(valid_b), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(err_b), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_rs(input longint acc, input int sh,
                                   output logic [15:0] y, output logic s);
    longint v;
    v = acc;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    s = 1'b1;
    if (v > 32767)       y = 16'h7FFF;
    else if (v < -32768) y = 16'h8000;
    else begin
      y = v[15:0];
      s = 1'b0;
    end
  endfunction

  task automatic model_accept(input logic [15:0] x);
    longint acc = 0;
    for (int k = N_TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
    for (int k = 0; k < N_TAPS; k++) acc += longint'(m_hist[k]) * longint'(m_coef[k]);
    model_rs(acc, 0,  exp_y_a, exp_s_a);
    model_rs(acc, 15, exp_y_b, exp_s_b);
  endtask

  task automatic model_clear_hist();
    for (int k = 0; k < N_TAPS; k++) m_hist[k] = '0;
  endtask

  // Called on the negedge following the accept edge, or later with start_lat cycles already spent.
  task automatic wait_out(input string tag, input int start_lat);
    int lat = start_lat;
    while (valid_a !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, N_TAPS);
    check({tag, "_valid_b"}, valid_b, 1'b1);
    check({tag, "_y_a"}, y_a, exp_y_a);
    check({tag, "_sat_a"}, sat_a, exp_s_a);
    check({tag, "_y_b"}, y_b, exp_y_b);
    check({tag, "_sat_b"}, sat_b, exp_s_b);
  endtask

  task automatic run_sample(input logic [15:0] x, input string tag);
    @(negedge clk);
    check({tag, "_ready"}, ready_a, 1'b1);
    check({tag, "_idle_valid"}, valid_a, 1'b0);
    in_valid = 1'b1;
    x_in     = x;
    model_accept(x);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(tag, 0);
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_idle_err", err_a, 1'b0);
    m_coef[a] = v;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", valid_a, 1'b0);
    model_clear_hist();
  endtask

  initial begin
    logic [15:0] x1, x2, y_hold;
    logic        saw;

    rst_p = 1'b1; x_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; flush = 1'b0;
    model_clear_hist();
    for (int k = 0; k < N_TAPS; k++) m_coef[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_a, 1'b1);
    check("rst_valid", valid_a, 1'b0);
    check("rst_y", y_a, 16'h0);
    check("rst_sat", sat_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    rst_p = 1'b0;

    // Impulse response equals the coefficient sequence, with exact latency.
    for (int k = 0; k < N_TAPS; k++) write_coef(2'(k), 16'(k + 1));
    for (int k = 0; k < N_TAPS; k++) begin
      run_sample((k == 0) ? 16'd1 : 16'd0, "imp");
      check("imp_const", y_a, 16'(k + 1));
    end

    // Saturation at both rails.
    for (int k = 0; k < N_TAPS; k++) write_coef(2'(k), 16'h7FFF);
    do_flush();
    run_sample(16'h7FFF, "satp");
    check("satp_const_y", y_a, 16'h7FFF);
    check("satp_const_s", sat_a, 1'b1);
    do_flush();
    run_sample(16'h8000, "satn");
    check("satn_const_y", y_a, 16'h8000);
    check("satn_const_s", sat_a, 1'b1);

    // Round half up on the shift-15 instance.
    write_coef(2'd0, 16'h4000);
    for (int k = 1; k < N_TAPS; k++) write_coef(2'(k), 16'h0000);
    do_flush();
    run_sample(16'd3, "rndp");
    check("rndp_const_y", y_b, 16'd2);
    check("rndp_const_s", sat_b, 1'b0);
    do_flush();
    run_sample(16'hFFFD, "rndn");
    check("rndn_const_y", y_b, 16'hFFFF);
    check("rndn_const_s", sat_b, 1'b0);

    // Backpressure with in_valid held high; a write during OUT must be dropped.
    write_coef(2'd0, 16'd3); write_coef(2'd1, 16'd5);
    write_coef(2'd2, 16'd7); write_coef(2'd3, 16'd11);
    x1 = 16'($urandom_range(0, 2000));
    x2 = 16'($urandom_range(0, 2000));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = x1;
    model_accept(x1);
    @(negedge clk);
    wait_out("bp", 0);
    y_hold = y_a;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'h1111;
      end
      @(negedge clk);
      coef_we = 1'b0;
      check("bp_valid", valid_a, 1'b1);
      check("bp_ready", ready_a, 1'b0);
      check("bp_y", y_a, exp_y_a);
      if (i == 3) check("bp_out_err", err_a, 1'b1);
    end
    check("bp_y_held", y_a, y_hold);
    x_in      = x2;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", valid_a, 1'b0);
    check("bp_rel_ready", ready_a, 1'b1);
    model_accept(x2);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", ready_a, 1'b0);
    wait_out("bp2", 0);

    // Coefficient write during MAC is dropped and flagged for one cycle.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 16'($urandom_range(0, 4000));
    model_accept(x_in);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 16'h1234;
    @(negedge clk);
    coef_we = 1'b0;
    check("mac_err_pulse", err_a, 1'b1);
    @(negedge clk);
    check("mac_err_clear", err_a, 1'b0);
    wait_out("macw", 2);

    // Flush mid-MAC: no result for that sample, then a clean impulse response.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 16'd77;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear_hist();
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (valid_a) saw = 1'b1;
    end
    check("flush_no_valid", saw, 1'b0);
    for (int k = 0; k < N_TAPS; k++) begin
      run_sample((k == 0) ? 16'd1 : 16'd0, "fimp");
      check("fimp_coef", y_a, m_coef[k]);
    end

    // Randomized coefficients and samples.
    for (int k = 0; k < N_TAPS; k++) write_coef(2'(k), 16'($urandom));
    for (int n = 0; n < 12; n++) run_sample(16'($urandom), "rnd");

    // Asynchronous reset in the middle of MAC.
    for (int k = 0; k < N_TAPS; k++) write_coef(2'(k), 16'(k + 100));
    run_sample(16'd50, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 16'd9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_p = 1'b1;
    #1;
    check("mrst_ready", ready_a, 1'b1);
    check("mrst_valid", valid_a, 1'b0);
    check("mrst_y", y_a, 16'h0);
    check("mrst_sat", sat_a, 1'b0);
    check("mrst_err", err_a, 1'b0);
    @(negedge clk);
    rst_p = 1'b0;
    model_clear_hist();
    for (int k = 0; k < N_TAPS; k++) m_coef[k] = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      run_sample((k == 0) ? 16'd1 : 16'd0, "zimp");
      check("zimp_zero", y_a, 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
